// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: bus widths, requester indices and the round-robin pointer wrap helper.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int DATA_BUS  = 32;

  localparam int CDB_ALU   = 0;
  localparam int CDB_LSB   = 1;
  localparam int CDB_BRU   = 2;
  localparam int CDB_N_REQ = 3;

  // Pointer advance past the winner; wraps n-1 -> 0 for any n, power of two or not.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational N-way round-robin select: first occupied slot at or after ptr, modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] occ,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    slot  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k never exceeds 2*N_REQ-2, so one conditional subtract is a full modulo.
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
      slot = sum[IDX_W-1:0];
      if (!any && occ[slot]) begin
        any         = 1'b1;
        grant[slot] = 1'b1;
        idx         = slot;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin broadcast on a
// registered CDB. Requires N_REQ >= 2.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int DATA_W = DATA_BUS,
  parameter int TAG_W  = ROB_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  input  logic [N_REQ*DATA_W-1:0]    req_value,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(N_REQ)-1:0]   cdb_src
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  occ_p0;
  logic [TAG_W-1:0]  tag_p0 [N_REQ];
  logic [DATA_W-1:0] val_p0 [N_REQ];
  logic [IDX_W-1:0]  ptr;

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic [IDX_W-1:0]  win;
  logic              any;
  logic              live;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .occ   (occ_p0),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign live      = rdy & ~clr;
  // A slot being granted this edge is free for a same-edge refill.
  assign req_ready = {N_REQ{live}} & (~occ_p0 | grant);
  assign accept    = req_valid & req_ready;

  // ---- p0: holding slots (data side, no reset) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        tag_p0[i] <= req_tag[i*TAG_W +: TAG_W];
        val_p0[i] <= req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- p1: slot occupancy, pointer and registered CDB ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_p0    <= '0;
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (rdy) begin
      if (clr) begin
        occ_p0    <= '0;
        cdb_valid <= 1'b0;
      end else begin
        occ_p0    <= (occ_p0 & ~grant) | accept;
        cdb_valid <= any;
        if (any) begin
          cdb_tag   <= tag_p0[win];
          cdb_value <= val_p0[win];
          cdb_src   <= win;
          ptr       <= IDX_W'(rr_next(int'(win), N_REQ));
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios push expected broadcasts, a monitor pops them.
module tb_cdb_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int IDX_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rdy;
  logic                    clr;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_value;
  logic [IDX_W-1:0]        cdb_src;

  cdb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [IDX_W-1:0]  src;
  } bc_t;

  bc_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic logic [DATA_W-1:0] val_of(input logic [TAG_W-1:0] t);
    return {16'hC0DE, 12'h000, t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] val, input logic [IDX_W-1:0] s);
    check(name, {cdb_valid, cdb_tag, cdb_value, cdb_src}, {v, t, val, s});
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    req_valid[i]                 = 1'b1;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_value[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic expect_bc(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                           input logic [IDX_W-1:0] s);
    bc_t b;
    b.tag   = t;
    b.value = v;
    b.src   = s;
    exp_q.push_back(b);
  endtask

  // Consume one clock edge; inputs are re-driven 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
    req_valid = '0;
    clr       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Monitor: a new broadcast is any cdb_valid following an edge that saw rdy high.
  always begin
    @(posedge clk);
    #1;
    if (!rst && rdy && cdb_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_broadcast: got tag %0d value 0x%0h src %0d, expected none",
                 cdb_tag, cdb_value, cdb_src);
      end else begin
        bc_t e;
        e = exp_q.pop_front();
        if ({cdb_tag, cdb_value, cdb_src} !== e) begin
          n_bad++;
          $display("FAIL broadcast: got tag %0d value 0x%0h src %0d, expected tag %0d value 0x%0h src %0d",
                   cdb_tag, cdb_value, cdb_src, e.tag, e.value, e.src);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    req_valid = '0; req_tag = '0; req_value = '0;
    #3;
    chk_cdb("reset_outputs", 1'b0, '0, '0, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("reset_ready", req_ready, 3'b111);

    // Single ALU result: tag 3, value 0x10
    set_req(0, 4'd3, 32'h0000_0010);
    expect_bc(4'd3, 32'h0000_0010, 2'd0);
    #1;
    check("single_ready0", req_ready[0], 1'b1);
    tick();
    chk_cdb("single_not_yet", 1'b0, '0, '0, '0);
    tick();
    chk_cdb("single_bcast", 1'b1, 4'd3, 32'h0000_0010, 2'd0);
    tick();
    check("single_pulse_end", cdb_valid, 1'b0);

    // BRU result moves ptr from 1 to 0
    set_req(2, 4'd9, val_of(4'd9));
    expect_bc(4'd9, val_of(4'd9), 2'd2);
    idle(3);

    // Contention: all three at once with ptr=0
    set_req(0, 4'd1, val_of(4'd1));
    set_req(1, 4'd2, val_of(4'd2));
    set_req(2, 4'd3, val_of(4'd3));
    expect_bc(4'd1, val_of(4'd1), 2'd0);
    expect_bc(4'd2, val_of(4'd2), 2'd1);
    expect_bc(4'd3, val_of(4'd3), 2'd2);
    #1;
    check("contend_ready", req_ready, 3'b111);
    tick();
    tick();
    chk_cdb("contend_first", 1'b1, 4'd1, val_of(4'd1), 2'd0);
    idle(3);
    check("contend_drained", cdb_valid, 1'b0);

    // Fairness: ALU every cycle, LSB once (tag 5); ptr=0
    expect_bc(4'd10, val_of(4'd10), 2'd0);
    expect_bc(4'd5,  val_of(4'd5),  2'd1);
    expect_bc(4'd11, val_of(4'd11), 2'd0);
    expect_bc(4'd12, val_of(4'd12), 2'd0);
    expect_bc(4'd13, val_of(4'd13), 2'd0);
    set_req(0, 4'd10, val_of(4'd10));
    set_req(1, 4'd5, val_of(4'd5));
    tick();
    set_req(0, 4'd11, val_of(4'd11));
    #1; check("fair_ready_c2", req_ready[0], 1'b1);
    tick();
    set_req(0, 4'd12, val_of(4'd12));
    #1; check("fair_ready_c3", req_ready[0], 1'b0);
    tick();
    set_req(0, 4'd12, val_of(4'd12));
    #1; check("fair_ready_c4", req_ready[0], 1'b1);
    tick();
    set_req(0, 4'd13, val_of(4'd13));
    #1; check("fair_ready_c5", req_ready[0], 1'b1);
    tick();
    idle(3);

    // Back-pressure and same-edge refill on BRU; ptr=1
    expect_bc(4'd4, val_of(4'd4), 2'd1);
    expect_bc(4'd6, val_of(4'd6), 2'd2);
    expect_bc(4'd7, val_of(4'd7), 2'd2);
    set_req(1, 4'd4, val_of(4'd4));
    set_req(2, 4'd6, val_of(4'd6));
    tick();
    set_req(2, 4'd7, val_of(4'd7));
    #1; check("bp_ready_losing", req_ready, 3'b011);
    tick();
    set_req(2, 4'd7, val_of(4'd7));
    #1; check("bp_ready_granted", req_ready, 3'b111);
    tick();
    idle(3);

    // Flush with two slots occupied; ptr=0
    set_req(0, 4'd8, val_of(4'd8));
    set_req(1, 4'd9, val_of(4'd9));
    tick();
    clr = 1'b1;
    set_req(2, 4'd12, val_of(4'd12));
    #1; check("flush_ready", req_ready, 3'b000);
    tick();
    check("flush_valid", cdb_valid, 1'b0);
    idle(2);
    set_req(0, 4'd14, val_of(4'd14));
    expect_bc(4'd14, val_of(4'd14), 2'd0);
    tick();
    idle(3);

    // Stall with cdb_valid high and pending slots, then async reset; ptr=1
    set_req(0, 4'd3, val_of(4'd3));
    set_req(1, 4'd4, val_of(4'd4));
    set_req(2, 4'd5, val_of(4'd5));
    expect_bc(4'd4, val_of(4'd4), 2'd1);
    tick();
    tick();
    rdy = 1'b0;
    #1;
    check("stall_ready", req_ready, 3'b000);
    chk_cdb("stall_hold_0", 1'b1, 4'd4, val_of(4'd4), 2'd1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_cdb("stall_hold", 1'b1, 4'd4, val_of(4'd4), 2'd1);
    end
    #3;
    rst = 1'b1;
    #1;
    chk_cdb("async_reset_outputs", 1'b0, '0, '0, '0);
    check("async_reset_ready", req_ready, 3'b000);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    check("post_reset_ready", req_ready, 3'b111);
    tick();
    idle(4);
    check("post_reset_idle", cdb_valid, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
